// File: rtl/tc_register_bank_arbiter.sv
// tc_register_bank_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share a bank of NUM_REGS
// load/save registers. Each operation takes three cycles: the request is
// latched in IDLE, the one-hot save/load strobe is issued in ISSUE, and the
// response is returned in RESP. The bank itself saves on the falling edge and
// loads on the rising edge, so a read issued after a write sees the new value.
module tc_register_bank_arbiter #(
    parameter int UUID       = 0,
    parameter     NAME       = "",
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BIT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [BIT_WIDTH-1:0]            rsp_rdata,
    output logic                            rsp_err,
    output logic [NUM_REGS-1:0]             reg_save,
    output logic [NUM_REGS-1:0]             reg_load,
    output logic [BIT_WIDTH-1:0]            reg_in,
    input  logic [NUM_REGS*BIT_WIDTH-1:0]   reg_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject parameter sets the arbitration and strobe logic cannot handle.
    if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_REGS < 1 || NUM_REGS > (1 << ADDR_WIDTH)) begin : g_param_check
        $error("tc_register_bank_arbiter %0d/%s: illegal parameterisation", UUID, NAME);
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        win_q, win_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BIT_WIDTH-1:0]    wdata_q, wdata_d;

    // Per-requester and per-register views of the flat buses.
    logic [ADDR_WIDTH-1:0]   req_addr_arr  [NUM_REQ];
    logic [BIT_WIDTH-1:0]    req_wdata_arr [NUM_REQ];
    logic [BIT_WIDTH-1:0]    reg_out_arr   [NUM_REGS];
    logic [NUM_REGS-1:0]     addr_hot;

    // Arbitration results.
    logic                    found;
    logic [PTR_W-1:0]        pick;
    logic [PTR_W:0]          idx_sum;

    logic                    addr_ok;
    logic [BIT_WIDTH-1:0]    sel_rdata;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_wdata_arr[gi] = req_wdata[gi*BIT_WIDTH +: BIT_WIDTH];
        end

        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign reg_out_arr[gi] = reg_out[gi*BIT_WIDTH +: BIT_WIDTH];
            assign addr_hot[gi]    = (addr_q == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Address beyond the populated bank produces no strobe and flags an error.
    assign addr_ok = ({1'b0, addr_q} < (ADDR_WIDTH+1)'(NUM_REGS));

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        pick    = rr_ptr_q;
        idx_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx_sum[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx_sum[PTR_W-1:0];
            end
        end
    end

    // Read data mux over the bank outputs, driven by the latched address.
    always_comb begin
        sel_rdata = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (addr_hot[r]) begin
                sel_rdata = sel_rdata | reg_out_arr[r];
            end
        end
    end

    // Next-state logic: latch the winner in IDLE, then walk ISSUE and RESP.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d  = ST_ISSUE;
                    win_d    = pick;
                    write_d  = req_write[pick];
                    addr_d   = req_addr_arr[pick];
                    wdata_d  = req_wdata_arr[pick];
                    rr_ptr_d = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + PTR_W'(1);
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: strobes only in ISSUE, response only in RESP, zero otherwise.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        reg_save  = '0;
        reg_load  = '0;
        reg_in    = '0;
        unique case (state_q)
            ST_ISSUE: begin
                req_ready[win_q] = 1'b1;
                if (write_q) begin
                    reg_in = wdata_q;
                end
                if (addr_ok) begin
                    if (write_q) begin
                        reg_save = addr_hot;
                    end else begin
                        reg_load = addr_hot;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid[win_q] = 1'b1;
                rsp_err          = ~addr_ok;
                if (!write_q && addr_ok) begin
                    rsp_rdata = sel_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and zeroes the pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_tc_register_bank_arbiter.sv
// Testbench for tc_register_bank_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model.
module tb_tc_register_bank_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 6;
    localparam int AW       = 3;
    localparam int BW       = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [NUM_REQ*AW-1:0]   req_addr;
    logic [NUM_REQ*BW-1:0]   req_wdata;
    logic [BW-1:0]           rsp_rdata, reg_in;
    logic                    rsp_err;
    logic [NUM_REGS-1:0]     reg_save, reg_load;
    logic [NUM_REGS*BW-1:0]  reg_out;

    // Requester-side pending requests (held until req_ready is seen).
    logic                    pend_v [NUM_REQ];
    logic                    pend_w [NUM_REQ];
    logic [AW-1:0]           pend_a [NUM_REQ];
    logic [BW-1:0]           pend_d [NUM_REQ];

    // Behavioural register bank: save on falling edge, load on rising edge.
    logic [BW-1:0]           bank_saved [NUM_REGS] = '{default: 8'h00};
    logic [BW-1:0]           bank_out   [NUM_REGS] = '{default: 8'h00};

    // Reference model state.
    logic [BW-1:0]           ref_mem   [NUM_REGS];
    bit                      ref_known [NUM_REGS];
    int                      edge_cnt, next_arb, m_ptr;
    bit                      op_act;
    int                      op_g, op_w;
    logic                    op_wr;
    logic [AW-1:0]           op_addr;
    logic [BW-1:0]           op_data;

    logic [NUM_REQ-1:0]      ready_seen;
    int                      grants[$];
    int                      exp_g[$];
    bit                      cont_mode, rand_mode, abort_armed;
    logic [BW-1:0]           last_rdata;
    logic                    last_err;
    int                      n_cmp, n_err;

    always #5 clk = ~clk;

    tc_register_bank_arbiter #(
        .UUID       (7),
        .NAME       ("bank0"),
        .NUM_REQ    (NUM_REQ),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (AW),
        .BIT_WIDTH  (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .reg_save  (reg_save),
        .reg_load  (reg_load),
        .reg_in    (reg_in),
        .reg_out   (reg_out)
    );

    always_comb begin
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]          = pend_v[i];
            req_write[i]          = pend_w[i];
            req_addr[i*AW +: AW]  = pend_a[i];
            req_wdata[i*BW +: BW] = pend_d[i];
        end
    end

    always_comb begin
        reg_out = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_out[r*BW +: BW] = bank_out[r];
        end
    end

    always @(negedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_save[r]) bank_saved[r] <= reg_in;
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_load[r]) bank_out[r] <= bank_saved[r];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] d);
        pend_v[i] = 1'b1;
        pend_w[i] = wr;
        pend_a[i] = a;
        pend_d[i] = d;
    endtask

    task automatic model_reset();
        op_act   = 1'b0;
        m_ptr    = 0;
        next_arb = 0;
    endtask

    // Arbitration rule at a rising edge: first valid requester from the pointer.
    task automatic model_edge();
        int  w;
        bit  hit;
        w   = 0;
        hit = 1'b0;
        if (rst !== 1'b1 || edge_cnt < next_arb) return;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (!hit && pend_v[idx]) begin
                hit = 1'b1;
                w   = idx;
            end
        end
        if (!hit) return;
        op_act   = 1'b1;
        op_g     = edge_cnt;
        op_w     = w;
        op_wr    = pend_w[w];
        op_addr  = pend_a[w];
        op_data  = pend_d[w];
        m_ptr    = (w + 1) % NUM_REQ;
        next_arb = edge_cnt + 3;
    endtask

    task automatic compare_outputs();
        logic [NUM_REQ-1:0]  e_ready, e_rv;
        logic [NUM_REGS-1:0] e_save, e_load;
        logic [BW-1:0]       e_in, e_rd;
        logic                e_err;
        bit                  chk_rd;
        bit                  is_issue, is_resp;
        e_ready = '0; e_rv = '0; e_save = '0; e_load = '0;
        e_in = '0; e_rd = '0; e_err = 1'b0; chk_rd = 1'b1;
        is_issue = op_act && (op_g == edge_cnt);
        is_resp  = op_act && (op_g + 1 == edge_cnt);
        if (is_issue) begin
            e_ready = NUM_REQ'(1 << op_w);
            if (op_wr) e_in = op_data;
            if (op_addr < NUM_REGS) begin
                if (op_wr) e_save = NUM_REGS'(1 << op_addr);
                else       e_load = NUM_REGS'(1 << op_addr);
            end
        end else if (is_resp) begin
            e_rv  = NUM_REQ'(1 << op_w);
            e_err = (op_addr >= NUM_REGS);
            if (!op_wr && op_addr < NUM_REGS) begin
                if (ref_known[op_addr]) e_rd = ref_mem[op_addr];
                else                    chk_rd = 1'b0;
            end
        end
        check("req_ready", req_ready, e_ready);
        check("reg_save",  reg_save,  e_save);
        check("reg_load",  reg_load,  e_load);
        check("reg_in",    reg_in,    e_in);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_err",   rsp_err,   e_err);
        if (chk_rd) check("rsp_rdata", rsp_rdata, e_rd);
        if (is_issue && op_wr && op_addr < NUM_REGS) begin
            ref_mem[op_addr]   = op_data;
            ref_known[op_addr] = 1'b1;
        end
        if (is_resp) begin
            $display("txn req%0d %s addr=%0d wdata=%02h rdata=%02h err=%0d",
                     op_w, op_wr ? "write" : "read ", op_addr, op_data, rsp_rdata, rsp_err);
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            op_act     = 1'b0;
        end
        ready_seen = req_ready;
        if (req_ready != '0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_ready[i]) begin
                    grants.push_back(i);
                    break;
                end
            end
        end
    endtask

    task automatic drive_update();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready_seen[i]) begin
                pend_v[i] = 1'b0;
                if (cont_mode) set_req(i, 1'b0, AW'(i), '0);
            end
            if (rand_mode && !pend_v[i] && $urandom_range(0, 2) == 0) begin
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                        BW'($urandom_range(0, 255)));
            end
        end
        ready_seen = '0;
    endtask

    // One clock: model at the rising edge, drive just after, check at the falling edge.
    task automatic step();
        @(posedge clk);
        edge_cnt++;
        model_edge();
        #1;
        drive_update();
        if (abort_armed && op_act && op_g == edge_cnt) begin
            check("pre_abort_ready", req_ready, NUM_REQ'(1 << op_w));
            #1 rst = 1'b0;
            #1;
            check("abort_ready", req_ready, '0);
            check("abort_save",  reg_save,  '0);
            check("abort_rsp",   rsp_valid, '0);
            check("abort_reg_in", reg_in,   '0);
            if (op_wr && op_addr < NUM_REGS) ref_known[op_addr] = 1'b0;
            model_reset();
            abort_armed = 1'b0;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_count"}, 64'(grants.size() >= exp_g.size()), 64'd1);
        for (int i = 0; i < exp_g.size(); i++) begin
            check(tag, (i < grants.size()) ? 64'(grants[i]) : 64'hFFFF, 64'(exp_g[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        n_cmp = 0; n_err = 0; edge_cnt = 0;
        cont_mode = 1'b0; rand_mode = 1'b0; abort_armed = 1'b0;
        ready_seen = '0; last_rdata = '0; last_err = 1'b0;
        op_g = 0; op_w = 0; op_wr = 1'b0; op_addr = '0; op_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_v[i] = 1'b0; pend_w[i] = 1'b0; pend_a[i] = '0; pend_d[i] = '0;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            ref_mem[r] = '0; ref_known[r] = 1'b1;
        end
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;

        // Single write: req0 writes 0xA5 to register 3.
        set_req(0, 1'b1, 3'd3, 8'hA5);
        repeat (4) step();

        // Read after write: req1 reads register 3.
        set_req(1, 1'b0, 3'd3, 8'h00);
        repeat (4) step();
        check("raw_rdata", last_rdata, 8'hA5);

        // Out-of-range: req2 reads address 7 with a 6-entry bank.
        set_req(2, 1'b0, 3'd7, 8'h00);
        repeat (4) step();
        check("oor_err", last_err, 1'b1);

        // Pointer wrap: pointer sits at 3, req3 and req0 pending.
        grants.delete();
        set_req(3, 1'b0, 3'd1, 8'h00);
        set_req(0, 1'b1, 3'd5, 8'h5A);
        repeat (8) step();
        exp_g = '{3, 0};
        check_grants("wrap_grant");

        // Round robin from a fresh reset with all requesters continuously valid.
        rst = 1'b0;
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        grants.delete();
        cont_mode = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, AW'(i), '0);
        repeat (16) step();
        cont_mode = 1'b0;
        exp_g = '{0, 1, 2, 3, 0};
        check_grants("rr_grant");
        repeat (16) step();

        // Reset during the ISSUE of a write by req1; pointer must restart at 0.
        set_req(1, 1'b1, 3'd2, 8'h3C);
        abort_armed = 1'b1;
        for (int i = 0; i < 10 && abort_armed; i++) step();
        check("abort_reached", 64'(abort_armed), 64'd0);
        set_req(0, 1'b0, 3'd5, 8'h00);
        set_req(2, 1'b0, 3'd0, 8'h00);
        repeat (2) step();
        rst = 1'b1;
        grants.delete();
        repeat (12) step();
        exp_g = '{0, 1, 2};
        check_grants("post_reset_grant");

        // Random traffic.
        rand_mode = 1'b1;
        repeat (900) step();
        rand_mode = 1'b0;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tc_register_bank_arbiter.md
# tc_register_bank_arbiter

Shares a bank of `NUM_REGS` load/save registers among `NUM_REQ` requesters. The registers capture `in` when `save` is high on the falling clock edge, and move the captured value to `out` when `load` is high on the rising edge. The block grants one request at a time in round-robin order, generates one-hot save or load strobes for the addressed register, and returns one response per request. It sits between requester logic (CPU datapath, DMA, debug port) and the register-bank instances.

## Interface

Parameters:

- `UUID`, 0, instance identifier; no functional effect.
- `NAME`, "", instance name; no functional effect.
- `NUM_REQ`, 4, number of requesters, 2..8.
- `NUM_REGS`, 8, number of registers in the bank, 1..2**`ADDR_WIDTH`.
- `ADDR_WIDTH`, 3, width of the register address.
- `BIT_WIDTH`, 8, register data width.

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  `NUM_REQ`  per-requester request.
- `req_write`  in  `NUM_REQ`  per-requester operation: 1 = write (save), 0 = read (load).
- `req_addr`  in  `NUM_REQ*ADDR_WIDTH`  flat bus; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  `NUM_REQ*BIT_WIDTH`  flat bus; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- `req_ready`  out  `NUM_REQ`  one-cycle grant pulse to the winner.
- `rsp_valid`  out  `NUM_REQ`  one-cycle completion pulse to the winner.
- `rsp_rdata`  out  `BIT_WIDTH`  read data, qualified by `rsp_valid`.
- `rsp_err`  out  1  address out of range, qualified by `rsp_valid`.
- `reg_save`  out  `NUM_REGS`  one-hot save strobes to the bank.
- `reg_load`  out  `NUM_REGS`  one-hot load strobes to the bank.
- `reg_in`  out  `BIT_WIDTH`  write data shared by all registers.
- `reg_out`  in  `NUM_REGS*BIT_WIDTH`  flat vector of all register `out` values.

## Operation

The block runs a three-state FSM: IDLE → ISSUE → RESP → IDLE.

- **IDLE:** if any `req_valid` is set, pick the winner.
  - The search starts at the round-robin pointer `rr_ptr`, increments, and wraps at `NUM_REQ`.
  - At the rising edge the block latches the winner index, `req_write`, address and wdata, and moves to ISSUE.
  - `rr_ptr` becomes winner+1, wrapping to 0 past `NUM_REQ`-1.
- **ISSUE (exactly 1 cycle):**
  - `req_ready[winner]`=1.
  - Write with a valid address: `reg_save[addr]`=1 and `reg_in` = latched wdata. The register captures the data on this cycle's falling edge. Its `out` does NOT change.
  - Read with a valid address: `reg_load[addr]`=1. The register's `out` takes its saved value at the rising edge that ends ISSUE.
  - An address ≥ `NUM_REGS` produces no strobe.
- **RESP (exactly 1 cycle):**
  - `rsp_valid[winner]`=1.
  - Read: `rsp_rdata` = `reg_out` slice at the latched address.
  - Write, or invalid address: `rsp_rdata`=0.
  - `rsp_err`=1 iff the address ≥ `NUM_REGS`.

Requester rules:

- Each requester holds `req_valid`, `req_write`, `req_addr` and `req_wdata` stable until it sees `req_ready`.
- Fields are latched in IDLE, so later changes do not affect the operation in flight.
- Deasserting `req_valid` before `req_ready` is a protocol violation. If it happens, the block still completes the latched operation.
- A requester may reassert `req_valid` in the cycle after `req_ready`. It is considered at the next IDLE.

Output rules outside the stated cycles:

- `reg_save` and `reg_load` are never multi-hot and never active outside ISSUE.
- `req_ready` and `rsp_valid` are at most one-hot.
- `reg_in`=0 except during a write ISSUE.

## Timing

- Latency: request sampled in IDLE at edge N; `req_ready` during cycle N+1 (ISSUE); `rsp_valid` during cycle N+2 (RESP).
- Throughput: one operation per 3 cycles. No pipelining and no back-to-back ISSUE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,`NUM_REQ`-1,0. The maximum wait is `NUM_REQ` operations.
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE and `rr_ptr`=0.
  - All outputs go to 0 immediately.
  - An operation in flight is aborted with no response. A save strobe already active may be cut short, and that register's value is then unspecified.
- After `rst` rises, the first arbitration happens at the first rising edge with `rst`=1.
- A read that follows a write to the same register returns the written data. The write is saved on the falling edge of its ISSUE cycle, the read loads it at its own ISSUE edge, and its RESP data is the written value.
- The arbiter does not drive the bank reset.

## Test plan

- Reset then a single write: req0 writes addr 3, 0xA5. Required: `req_ready`=0001 in cycle +1 with `reg_save`=00001000 and `reg_in`=0xA5; `rsp_valid`=0001 in cycle +2 with `rsp_err`=0 and `rsp_rdata`=0.
- Read after write: req1 reads addr 3 after the write above. Required: `reg_load`=00001000 in ISSUE; `rsp_valid`=0010 with `rsp_rdata`=0xA5 in RESP.
- Round robin: all four requesters valid continuously, reading addrs 0..3. Required: grants in order 0,1,2,3,0; one `rsp_valid` pulse every 3 cycles; never two bits set.
- Out-of-range address: `NUM_REGS`=6, req2 reads addr 7. Required: no `reg_load` or `reg_save` bit set; `rsp_valid`=0100 with `rsp_err`=1 and `rsp_rdata`=0.
- Reset mid-operation: pull `rst` low during ISSUE of a write. Required: `reg_save`, `req_ready` and `rsp_valid` go to 0 immediately with no RESP pulse; after release, req0 pending is granted first (`rr_ptr`=0).
- Pointer wrap: only req3 then req0 valid. Required: req3 granted, then req0 granted on the next IDLE; `rr_ptr` wraps 3→0.
